// File: rtl/complex_vxc_pkg.sv
// Shared types and helpers for the complex axpy chunk sequencer.
package complex_vxc_pkg;

    localparam int ELEMENT_WIDTH = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;

    function automatic int nchunk(input int noe, input int ni);
        return (noe + ni - 1) / ni;
    endfunction

    // MSB bit position of lane j; lane 0 is the most significant slice.
    function automatic int lane(input int j, input int ni, input int ew);
        return ew * (ni - j) - 1;
    endfunction

    function automatic logic lane_real_in_last(input int j, input int noe, input int ni);
        return ((noe % ni) == 0) || (j < (noe % ni));
    endfunction

endpackage

// File: rtl/complex_vxc_valid_pipe.sv
// Delay line carrying {valid, chunk index, last} alongside the read/datapath pipeline.
module complex_vxc_valid_pipe #(
    parameter int DEPTH = 9,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [AW-1:0] in_idx,
    input  logic          in_last,
    output logic          s1_valid,
    output logic          s1_last,
    output logic          s2_valid,
    output logic          out_valid,
    output logic [AW-1:0] out_idx,
    output logic          out_last
);

    logic [DEPTH:1]         vld_pipe;
    logic [DEPTH:1]         last_pipe;
    logic [DEPTH:1][AW-1:0] idx_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            idx_pipe  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[DEPTH-1:1], in_valid};
            last_pipe <= {last_pipe[DEPTH-1:1], in_last};
            idx_pipe  <= {idx_pipe[DEPTH-1:1], in_idx};
        end
    end

    assign s1_valid  = vld_pipe[1];
    assign s1_last   = last_pipe[1];
    assign s2_valid  = vld_pipe[2];
    assign out_valid = vld_pipe[DEPTH];
    assign out_idx   = idx_pipe[DEPTH];
    assign out_last  = last_pipe[DEPTH];

endmodule

// File: rtl/complex_vxc_chunk_sequencer.sv
// Chunk sequencer for the complex axpy datapath: read, zero-pad, feed, write back.
// Optional COMPLEX_VXC_SEQ_CYCLE_COUNT_EN adds a cycle_count output.
module complex_vxc_chunk_sequencer #(
    parameter int NOE           = 19,
    parameter int NI            = 8,
    parameter int ELEMENT_WIDTH = complex_vxc_pkg::ELEMENT_WIDTH,
    parameter int PIPE_LATENCY  = 7,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        op_in,
    input  logic [ELEMENT_WIDTH-1:0]    constant_in,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [ELEMENT_WIDTH*NI-1:0] rd_data_a,
    input  logic [ELEMENT_WIDTH*NI-1:0] rd_data_b,
    output logic [ELEMENT_WIDTH*NI-1:0] dp_first_row,
    output logic [ELEMENT_WIDTH*NI-1:0] dp_second_row,
    output logic [ELEMENT_WIDTH-1:0]    dp_constant,
    output logic                        dp_op,
    output logic                        dp_valid,
    input  logic [ELEMENT_WIDTH*NI-1:0] dp_result,
    output logic                        wr_en,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic [ELEMENT_WIDTH*NI-1:0] wr_data,
    output logic [NI-1:0]               wr_mask
`ifdef COMPLEX_VXC_SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]                 cycle_count
`endif
);
    import complex_vxc_pkg::*;

    localparam int EW     = ELEMENT_WIDTH;
    localparam int W      = EW * NI;
    localparam int NCHUNK = nchunk(NOE, NI);
    localparam int DEPTH  = 2 + PIPE_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NCHUNK - 1);

    seq_state_t            state;
    logic                  s1_valid, s1_last, s2_valid, out_valid, out_last;
    logic [ADDR_WIDTH-1:0] out_idx;
    logic [NI-1:0]         last_mask;
    logic [W-1:0]          pad_a, pad_b;

    complex_vxc_valid_pipe #(.DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_valid_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en),
        .in_idx    (rd_addr),
        .in_last   (rd_addr == LAST_ADDR),
        .s1_valid  (s1_valid),
        .s1_last   (s1_last),
        .s2_valid  (s2_valid),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Lanes past the end of the vector read as zero in the final chunk.
    for (genvar j = 0; j < NI; j++) begin : g_lane
        localparam int HI = lane(j, NI, EW);
        assign last_mask[NI-1-j] = lane_real_in_last(j, NOE, NI);
        assign pad_a[HI -: EW] = (s1_last && !last_mask[NI-1-j]) ? '0 : rd_data_a[HI -: EW];
        assign pad_b[HI -: EW] = (s1_last && !last_mask[NI-1-j]) ? '0 : rd_data_b[HI -: EW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_first_row  <= '0;
            dp_second_row <= '0;
        end else if (s1_valid) begin
            dp_first_row  <= pad_a;
            dp_second_row <= pad_b;
        end
    end

    assign dp_valid = s2_valid;
    assign wr_en    = out_valid;
    assign wr_addr  = out_idx;
    assign wr_data  = out_valid ? dp_result : '0;
    assign wr_mask  = out_valid ? (out_last ? last_mask : '1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            dp_op       <= 1'b0;
            dp_constant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        rd_en       <= 1'b1;
                        rd_addr     <= '0;
                        dp_op       <= op_in;
                        dp_constant <= constant_in;
                    end
                end
                ISSUE: begin
                    if (rd_addr == LAST_ADDR) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COMPLEX_VXC_SEQ_CYCLE_COUNT_EN
    // Counts the start cycle as 1 and freezes once DONE is reached.
    always_ff @(posedge clk) begin
        if (reset)
            cycle_count <= '0;
        else if (state == IDLE && start)
            cycle_count <= 16'd1;
        else if (busy && state != DONE)
            cycle_count <= cycle_count + 16'd1;
    end
`else
    // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_complex_vxc_chunk_sequencer.sv
// Scoreboard bench for complex_vxc_chunk_sequencer (NOE=19 and NOE=16 instances).
module tb_complex_vxc_chunk_sequencer;
    localparam int NI = 8, EW = 64, W = NI * EW, AW = 8;

    typedef struct {
        int            cyc;
        int            addr;
        logic [NI-1:0] mask;
        logic [W-1:0]  data;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, op_in = 1'b0;
    logic [EW-1:0] constant_in = '0;

    logic busy, done, rd_en, dp_op, dp_valid, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0] rd_data_a, rd_data_b, dp_first_row, dp_second_row, dp_result, wr_data;
    logic [EW-1:0] dp_constant;
    logic [NI-1:0] wr_mask;

    logic busy16, done16, rd_en16, dp_op16, dp_valid16, wr_en16;
    logic [AW-1:0] rd_addr16, wr_addr16;
    logic [W-1:0] rd_data_a16, rd_data_b16, dp_first_row16, dp_second_row16, dp_result16, wr_data16;
    logic [EW-1:0] dp_constant16;
    logic [NI-1:0] wr_mask16;
`ifdef COMPLEX_VXC_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_count, cycle_count16;
`endif

    int cyc = 0, errors = 0, checks = 0;
    bit cmode = 1'b0;
    exp_t q_rd[$], q_dp[$], q_wr[$], q_wr16[$];
    int q_done[$], q_done16[$];

    complex_vxc_chunk_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op_in(op_in), .constant_in(constant_in),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .dp_first_row(dp_first_row), .dp_second_row(dp_second_row),
        .dp_constant(dp_constant), .dp_op(dp_op), .dp_valid(dp_valid), .dp_result(dp_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
`ifdef COMPLEX_VXC_SEQ_CYCLE_COUNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    complex_vxc_chunk_sequencer #(.NOE(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .op_in(op_in), .constant_in(constant_in),
        .busy(busy16), .done(done16), .rd_en(rd_en16), .rd_addr(rd_addr16),
        .rd_data_a(rd_data_a16), .rd_data_b(rd_data_b16),
        .dp_first_row(dp_first_row16), .dp_second_row(dp_second_row16),
        .dp_constant(dp_constant16), .dp_op(dp_op16), .dp_valid(dp_valid16), .dp_result(dp_result16),
        .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16), .wr_mask(wr_mask16)
`ifdef COMPLEX_VXC_SEQ_CYCLE_COUNT_EN
        , .cycle_count(cycle_count16)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EW-1:0] elem(int c, int j, bit b);
        if (cmode) return 64'h3f800000_3f800000;
        return {(b ? 8'hbb : 8'haa), 40'h0, 8'(c), 8'(j)};
    endfunction

    function automatic logic [W-1:0] row(int c, int noe, bit b, bit pad);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < NI; j++)
            if (!pad || (c * NI + j) < noe) r[EW*(NI-j)-1 -: EW] = elem(c, j, b);
        return r;
    endfunction

    function automatic logic [NI-1:0] mask(int c, int noe);
        logic [NI-1:0] m;
        for (int j = 0; j < NI; j++) m[NI-1-j] = ((c * NI + j) < noe);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Banked memory (1-cycle read) and a 7-stage stand-in datapath computing first+second.
    logic [W-1:0] dpq[7], dpq16[7];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= row(int'(rd_addr), 0, 1'b0, 1'b0);
            rd_data_b <= row(int'(rd_addr), 0, 1'b1, 1'b0);
        end
        if (rd_en16) begin
            rd_data_a16 <= row(int'(rd_addr16), 0, 1'b0, 1'b0);
            rd_data_b16 <= row(int'(rd_addr16), 0, 1'b1, 1'b0);
        end
        dpq[0]   <= dp_first_row + dp_second_row;
        dpq16[0] <= dp_first_row16 + dp_second_row16;
        for (int i = 1; i < 7; i++) begin
            dpq[i]   <= dpq[i-1];
            dpq16[i] <= dpq16[i-1];
        end
    end
    assign dp_result   = dpq[6];
    assign dp_result16 = dpq16[6];

    always @(negedge clk) if (!reset) begin
        exp_t e;
        if (rd_en) begin
            if (q_rd.size() == 0) chk("rd_extra", W'(rd_en), '0);
            else begin
                e = q_rd.pop_front();
                chk("rd_cyc", W'(cyc), W'(e.cyc));
                chk("rd_addr", W'(rd_addr), W'(e.addr));
            end
        end
        if (dp_valid) begin
            if (q_dp.size() == 0) chk("dp_extra", W'(dp_valid), '0);
            else begin
                e = q_dp.pop_front();
                chk("dp_cyc", W'(cyc), W'(e.cyc));
                chk("dp_first", dp_first_row, e.data);
                chk("dp_second", dp_second_row, row(e.addr, 19, 1'b1, 1'b1));
            end
        end
        if (wr_en) begin
            if (q_wr.size() == 0) chk("wr_extra", W'(wr_en), '0);
            else begin
                e = q_wr.pop_front();
                chk("wr_cyc", W'(cyc), W'(e.cyc));
                chk("wr_addr", W'(wr_addr), W'(e.addr));
                chk("wr_mask", W'(wr_mask), W'(e.mask));
                chk("wr_data", wr_data, e.data);
            end
        end
        if (done) begin
            if (q_done.size() == 0) chk("done_extra", W'(done), '0);
            else chk("done_cyc", W'(cyc), W'(q_done.pop_front()));
        end
    end

    always @(negedge clk) if (!reset) begin
        exp_t e;
        if (wr_en16) begin
            if (q_wr16.size() == 0) chk("wr16_extra", W'(wr_en16), '0);
            else begin
                e = q_wr16.pop_front();
                chk("wr16_cyc", W'(cyc), W'(e.cyc));
                chk("wr16_addr", W'(wr_addr16), W'(e.addr));
                chk("wr16_mask", W'(wr_mask16), W'(e.mask));
                chk("wr16_data", wr_data16, e.data);
            end
        end
        if (done16) begin
            if (q_done16.size() == 0) chk("done16_extra", W'(done16), '0);
            else chk("done16_cyc", W'(cyc), W'(q_done16.pop_front()));
        end
    end

    task automatic run(input bit op, input logic [EW-1:0] k, input bit mid_start, input bit mid_rst);
        int s;
        @(negedge clk);
        op_in = op; constant_in = k; start = 1'b1; s = cyc;
        for (int c = 0; c < 3; c++) begin
            q_rd.push_back('{s + 1 + c, c, '0, '0});
            q_dp.push_back('{s + 3 + c, c, '0, row(c, 19, 1'b0, 1'b1)});
            q_wr.push_back('{s + 10 + c, c, mask(c, 19), row(c, 19, 1'b0, 1'b1) + row(c, 19, 1'b1, 1'b1)});
        end
        q_done.push_back(s + 13);
        for (int c = 0; c < 2; c++)
            q_wr16.push_back('{s + 10 + c, c, mask(c, 16), row(c, 16, 1'b0, 1'b1) + row(c, 16, 1'b1, 1'b1)});
        q_done16.push_back(s + 12);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 2) chk("busy_on", W'(busy), W'(1));
            if (mid_start && i == 4) begin op_in = ~op; constant_in = ~k; end
            if (mid_start && i == 5) start = 1'b1;
            if (i == 6) begin
                chk("dp_op", W'(dp_op), W'(op));
                chk("dp_constant", W'(dp_constant), W'(k));
            end
            if (mid_rst && i == 8) begin
                reset = 1'b1;
                q_wr.delete(); q_wr16.delete(); q_done.delete(); q_done16.delete();
            end
            if (mid_rst && i == 9) reset = 1'b0;
            if (mid_rst && i == 10) begin
                chk("abort_busy", W'(busy), '0);
                chk("abort_done", W'(done), '0);
                chk("abort_wr", W'(wr_en), '0);
            end
`ifdef COMPLEX_VXC_SEQ_CYCLE_COUNT_EN
            if (!mid_rst && i == 13) chk("cc_done", W'(cycle_count), W'(13));
            if (!mid_rst && i == 17) chk("cc_hold", W'(cycle_count), W'(13));
`endif
            if (!mid_rst && i == 14) begin
                chk("busy_off", W'(busy), '0);
                chk("busy16_off", W'(busy16), '0);
            end
        end
        chk("pending_wr", W'(q_wr.size()), '0);
        chk("pending_dp", W'(q_dp.size()), '0);
        chk("pending_done", W'(q_done.size()), '0);
        chk("pending_wr16", W'(q_wr16.size()), '0);
        chk("pending_done16", W'(q_done16.size()), '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_rd_en", W'(rd_en), '0);
        chk("rst_rd_addr", W'(rd_addr), '0);
        chk("rst_dp_valid", W'(dp_valid), '0);
        chk("rst_dp_row", dp_first_row, '0);
        chk("rst_dp_constant", W'(dp_constant), '0);
        chk("rst_wr_en", W'(wr_en), '0);
        chk("rst_wr_mask", W'(wr_mask), '0);
        chk("rst_wr_data", wr_data, '0);
`ifdef COMPLEX_VXC_SEQ_CYCLE_COUNT_EN
        chk("rst_cc", W'(cycle_count), '0);
`endif
        reset = 1'b0;

        run(1'b0, 64'h40000000_3f800000, 1'b0, 1'b0);
        cmode = 1'b1;
        run(1'b1, 64'hbf800000_00000000, 1'b0, 1'b0);
        cmode = 1'b0;
        run(1'b1, 64'h12345678_9abcdef0, 1'b1, 1'b0);
        run(1'b0, 64'h3f800000_40400000, 1'b0, 1'b1);
        run(1'b0, 64'h40a00000_c0000000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
